alu_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle datapath ALU; sits in the EX stage and stalls the pipeline through busy.
- Keeps the existing 4-bit op encoding for 0000-1011; adds sra, sltu and signed/unsigned divide.
- Replaces the combinational multiply with an iterative shift-add multiplier; adds an iterative restoring divider.
- All outputs are registered.

---
 rtl/alu_mc.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_mc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage ALU. Single-cycle logic/arith/shift/compare ops,
// an iterative shift-add signed multiplier and an iterative restoring divider
// (signed and unsigned). All outputs come straight from flops.
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  // Multiply: {upper partial sum, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend/quotient shift register}.
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             zero_hold_q, zero_hold_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] a_mag, b_mag, div_a, div_b;
  logic             div_signed;

  // One shift-add step: conditionally add the multiplicand to the upper half,
  // then shift the whole accumulator right by one.
  function automatic logic [W2-1:0] mul_step(input logic [W2-1:0] p,
                                             input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, p[W2-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, p[WIDTH-1:1]};
  endfunction

  // One restoring-division step: shift in the next dividend bit, keep the
  // trial difference only if it did not go negative.
  function automatic logic [W2-1:0] div_step(input logic [W2-1:0] p,
                                             input logic [WIDTH-1:0] d);
    logic [WIDTH:0]  sh, df;
    logic [W2-1:0]   r;
    sh = {p[W2-1:WIDTH], p[WIDTH-1]};
    df = sh - {1'b0, d};
    if (df[WIDTH]) r = {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    else           r = {df[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    return r;
  endfunction

  // Operand magnitudes for the signed iterative ops; divu uses raw operands.
  always_comb begin
    a_mag      = A[WIDTH-1] ? (WIDTH'(0) - A) : A;
    b_mag      = B[WIDTH-1] ? (WIDTH'(0) - B) : B;
    div_signed = (ctrl == 4'b1110);
    div_a      = div_signed ? a_mag : A;
    div_b      = div_signed ? b_mag : B;
  end

  // Single-cycle result selection by opcode.
  always_comb begin
    alu_res = '0;
    case (ctrl)
      4'b0000, 4'b0001: alu_res = A + B;
      4'b0010:          alu_res = A - B;
      4'b0100:          alu_res = A << B[SHW-1:0];
      4'b0101:          alu_res = A >> B[SHW-1:0];
      4'b1100:          alu_res = $signed(A) >>> B[SHW-1:0];
      4'b0110:          alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1101:          alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b0111, 4'b1000: alu_res = A & B;
      4'b1001, 4'b1010: alu_res = A | B;
      4'b1011:          alu_res = ~(A | B);
      default:          alu_res = '0;
    endcase
  end

  // Next-state and datapath control: launch from IDLE, iterate in MUL/DIV,
  // write all outputs together with the done pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    zero_hold_d = zero_hold_q;
    result_d    = result_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (ctrl)
            4'b0011: begin
              opnd_d      = a_mag;
              acc_d       = mul_step({{WIDTH{1'b0}}, b_mag}, a_mag);
              neg_lo_d    = A[WIDTH-1] ^ B[WIDTH-1];
              zero_hold_d = (A == B);
              cnt_d       = SHW'(1);
              busy_d      = 1'b1;
              state_d     = S_MUL;
            end
            4'b1110, 4'b1111: begin
              if (B == '0) begin
                result_d = '1;
                hi_d     = A;
                zero_d   = (A == B);
                dbz_d    = 1'b1;
                done_d   = 1'b1;
              end else begin
                opnd_d      = div_b;
                acc_d       = div_step({{WIDTH{1'b0}}, div_a}, div_b);
                neg_lo_d    = div_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                neg_hi_d    = div_signed & A[WIDTH-1];
                zero_hold_d = (A == B);
                cnt_d       = SHW'(1);
                busy_d      = 1'b1;
                state_d     = S_DIV;
              end
            end
            default: begin
              result_d = alu_res;
              hi_d     = '0;
              zero_d   = (A == B);
              dbz_d    = 1'b0;
              done_d   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_step(acc_q, opnd_q);
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH-1)) begin
          {hi_d, result_d} = neg_lo_q ? (W2'(0) - acc_d) : acc_d;
          zero_d  = zero_hold_q;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        acc_d = div_step(acc_q, opnd_q);
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH-1)) begin
          result_d = neg_lo_q ? (WIDTH'(0) - acc_d[WIDTH-1:0]) : acc_d[WIDTH-1:0];
          hi_d     = neg_hi_q ? (WIDTH'(0) - acc_d[W2-1:WIDTH]) : acc_d[W2-1:WIDTH];
          zero_d   = zero_hold_q;
          dbz_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      zero_hold_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      zero_hold_q <= zero_hold_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign result      = result_q;
  assign hi          = hi_q;
  assign zero        = zero_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at WIDTH=32 and WIDTH=8. Expected
// responses come from a wide-integer reference model and are queued at launch;
// monitors pop and compare whenever a DUT pulses done.
module tb_alu_mc;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        dbz;
    longint      done_at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start32 = 1'b0;
  logic [3:0]  ctrl32  = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [31:0] result32, hi32;
  logic        zero32, busy32, done32, dbz32;

  logic        start8 = 1'b0;
  logic [3:0]  ctrl8  = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  result8, hi8;
  logic        zero8, busy8, done8, dbz8;

  longint      cyc = 0;
  int          num_checks = 0;
  int          num_fails  = 0;
  int          dones32 = 0;
  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        mon32_e, mon8_e;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .ctrl(ctrl32), .A(a32), .B(b32),
    .result(result32), .hi(hi32), .zero(zero32), .busy(busy32), .done(done32),
    .div_by_zero(dbz32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .ctrl(ctrl8), .A(a8), .B(b8),
    .result(result8), .hi(hi8), .zero(zero8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain 64-bit integer arithmetic on sign/zero-extended operands.
  function automatic exp_t modelOp(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input int w, input longint now);
    exp_t   e;
    longint mask, ua, ub, sa, sb, r, h, p;
    int     sh, lat;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua << (64 - w)) >>> (64 - w);
    sb   = (ub << (64 - w)) >>> (64 - w);
    sh   = int'(ub % longint'(w));
    r = 0; h = 0; lat = 1; e.dbz = 1'b0;
    case (c)
      4'b0000, 4'b0001: r = (ua + ub) & mask;
      4'b0010:          r = (ua - ub) & mask;
      4'b0100:          r = (ua << sh) & mask;
      4'b0101:          r = ua >> sh;
      4'b1100:          r = (sa >>> sh) & mask;
      4'b0110:          r = (sa < sb) ? 1 : 0;
      4'b1101:          r = (ua < ub) ? 1 : 0;
      4'b0111, 4'b1000: r = ua & ub;
      4'b1001, 4'b1010: r = ua | ub;
      4'b1011:          r = ~(ua | ub) & mask;
      4'b0011: begin
        p = sa * sb;
        r = p & mask;
        h = (p >>> w) & mask;
        lat = w;
      end
      default: begin
        if (ub == 0) begin
          r = mask; h = ua; e.dbz = 1'b1; lat = 1;
        end else if (c == 4'b1110) begin
          r = (sa / sb) & mask; h = (sa % sb) & mask; lat = w;
        end else begin
          r = ua / ub; h = ua % ub; lat = w;
        end
      end
    endcase
    e.res     = 32'(r);
    e.hi      = 32'(h);
    e.z       = (ua == ub);
    e.done_at = now + longint'(lat);
    return e;
  endfunction

  function automatic logic [31:0] pickOperand(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h1 << (w - 1);
      3:       v = 32'h1;
      4:       v = $urandom_range(0, 9);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
    num_checks++;
    if (act !== req) begin
      num_fails++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e, input logic [31:0] res,
                             input logic [31:0] hi, input logic z, input logic dbz,
                             input logic bsy);
    checkField({name, " result"}, res, e.res);
    checkField({name, " hi"}, hi, e.hi);
    checkField({name, " zero"}, {31'b0, z}, {31'b0, e.z});
    checkField({name, " div_by_zero"}, {31'b0, dbz}, {31'b0, e.dbz});
    checkField({name, " busy_at_done"}, {31'b0, bsy}, 32'h0);
    checkField({name, " done_cycle"}, 32'(cyc), 32'(e.done_at));
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (!rst && done32) begin
      dones32++;
      if (q32.size() == 0) begin
        num_checks++; num_fails++;
        $display("[TB] FAIL w32 unexpected_done: actual done=1 required no pulse (cycle %0d)", cyc);
      end else begin
        mon32_e = q32.pop_front();
        checkOutput("w32", mon32_e, result32, hi32, zero32, dbz32, busy32);
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        num_checks++; num_fails++;
        $display("[TB] FAIL w8 unexpected_done: actual done=1 required no pulse (cycle %0d)", cyc);
      end else begin
        mon8_e = q8.pop_front();
        checkOutput("w8", mon8_e, {24'b0, result8}, {24'b0, hi8}, zero8, dbz8, busy8);
      end
    end
  end

  // Called at a negedge; waits for idle, launches one op, returns at the next negedge.
  task automatic applyStimulus(input bit use8, input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b, input bit hold);
    int guard;
    guard = 0;
    while ((use8 ? busy8 : busy32) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      num_checks++; num_fails++;
      $display("[TB] FAIL busy_timeout: actual busy=1 required idle within 200 cycles");
    end
    if (use8) begin
      ctrl8 = c; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
      q8.push_back(modelOp(c, a, b, 8, cyc));
    end else begin
      ctrl32 = c; a32 = a; b32 = b; start32 = 1'b1;
      q32.push_back(modelOp(c, a, b, 32, cyc));
    end
    @(negedge clk);
    if (!hold) begin
      if (use8) begin
        start8 = 1'b0; ctrl8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
        start32 = 1'b0; ctrl32 = 4'($urandom); a32 = $urandom; b32 = $urandom;
      end
    end
  endtask

  task automatic countBusy(input bit use8, output int n);
    int guard;
    n = 0; guard = 0;
    while (!(use8 ? done8 : done32) && guard < 100) begin
      if (use8 ? busy8 : busy32) n++;
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q32.size() != 0 || q8.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      num_checks++; num_fails++;
      $display("[TB] FAIL drain_timeout: actual pending=%0d required 0", q32.size() + q8.size());
    end
  endtask

  initial begin
    int n;
    int d0;
    int guard;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkField("reset result32", result32, 32'h0);
    checkField("reset hi32", hi32, 32'h0);
    checkField("reset flags32", {28'b0, zero32, busy32, done32, dbz32}, 32'h0);
    checkField("reset result8", {24'b0, result8}, 32'h0);
    checkField("reset hi8", {24'b0, hi8}, 32'h0);
    checkField("reset flags8", {28'b0, zero8, busy8, done8, dbz8}, 32'h0);

    $display("[TB] directed single-cycle and iterative ops");
    applyStimulus(0, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    applyStimulus(0, 4'b1100, 32'h8000_0000, 32'h0000_0024, 0);
    applyStimulus(0, 4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    applyStimulus(0, 4'b1101, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    applyStimulus(0, 4'b0011, 32'hFFFF_FFFD, 32'h4000_0000, 0);
    countBusy(0, n);
    checkField("mul_busy_cycles", 32'(n), 32'd31);
    applyStimulus(0, 4'b1110, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    applyStimulus(0, 4'b1111, 32'h0000_0007, 32'h0000_0000, 0);
    applyStimulus(0, 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(0, 4'b0010, 32'h0000_0005, 32'h0000_0005, 0);

    $display("[TB] random ops, width 32");
    for (int i = 0; i < 150; i++)
      applyStimulus(0, 4'($urandom), pickOperand(32), pickOperand(32), 0);
    drain();

    $display("[TB] start held high through a multiply");
    d0 = dones32;
    applyStimulus(0, 4'b0011, $urandom, $urandom, 1);
    guard = 0;
    while (!done32 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    start32 = 1'b0;
    repeat (40) @(negedge clk);
    checkField("held_start_dones", 32'(dones32 - d0), 32'd1);

    $display("[TB] width 8 instance");
    applyStimulus(1, 4'b0011, 32'h80, 32'h80, 0);
    countBusy(1, n);
    checkField("mul8_busy_cycles", 32'(n), 32'd7);
    for (int i = 0; i < 100; i++)
      applyStimulus(1, 4'($urandom), pickOperand(8), pickOperand(8), 0);
    drain();

    $display("[TB] reset during multiply");
    applyStimulus(0, 4'b0000, 32'h1234_5678, 32'h1111_1111, 0);
    applyStimulus(0, 4'b0011, 32'h1234_5678, 32'h9ABC_DEF1, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    q32.delete();
    d0 = dones32;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkField("midop_reset result", result32, 32'h0);
    checkField("midop_reset hi", hi32, 32'h0);
    checkField("midop_reset zero", {31'b0, zero32}, 32'h0);
    checkField("midop_reset busy", {31'b0, busy32}, 32'h0);
    checkField("midop_reset done", {31'b0, done32}, 32'h0);
    checkField("midop_reset div_by_zero", {31'b0, dbz32}, 32'h0);
    repeat (50) @(negedge clk);
    checkField("midop_reset no_done", 32'(dones32 - d0), 32'd0);

    applyStimulus(0, 4'b1111, 32'd100, 32'd7, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual still running required finish before 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
